// File: rtl/mips_cpu_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU.
// Works on operand magnitudes, one quotient bit per clock, then a sign fixup.
module mips_cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic             r_neg_dvd;
    logic             r_neg_dvs;
    logic             r_zero;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;

    logic             w_accept;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic             w_q_neg;
    logic             w_r_neg;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (sign && divisor[WIDTH-1]) ? -divisor : divisor;

    // Partial remainder stays below the divisor, so a 33-bit trial
    // subtraction is enough: bit WIDTH set means the trial went negative.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_trial[WIDTH];

    assign w_q_neg = r_sign && (r_neg_dvd ^ r_neg_dvs);
    assign w_r_neg = r_sign && r_neg_dvd;

    // On divide-by-zero r_quo still holds the latched dividend magnitude.
    assign w_q_fix = r_zero  ? '1 :
                     w_q_neg ? -r_quo : r_quo;
    assign w_r_fix = r_zero  ? (w_r_neg ? -r_quo : r_quo) :
                     w_r_neg ? -r_rem : r_rem;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (divisor == '0) ? S_FIXUP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_neg_dvs <= 1'b0;
            r_zero    <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sign    <= sign;
                r_neg_dvd <= dividend[WIDTH-1];
                r_neg_dvs <= divisor[WIDTH-1];
                r_zero    <= (divisor == '0);
                r_quo     <= w_dvd_mag;
                r_div     <= w_dvs_mag;
                r_rem     <= '0;
                r_cnt     <= CW'(WIDTH);
                r_done    <= 1'b0;
                r_dbz     <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == S_FIXUP) begin
                r_q_out <= w_q_fix;
                r_r_out <= w_r_fix;
                r_dbz   <= r_zero;
                r_done  <= 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign dbz       = r_dbz;
    assign quotient  = r_q_out;
    assign remainder = r_r_out;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Directed and randomized checks of mips_cpu_divider against a
// truncating-division reference model.
module tb_mips_cpu_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done;
    logic        dbz;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_chk = 0;
    int n_err = 0;

    mips_cpu_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (done),
        .dbz      (dbz),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Pulse start for edge E0, then scramble the inputs.
    task automatic launch(input logic s, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        sign     = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        sign     = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ed, input int lat);
        int n;
        launch(s, a, b);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, 32'(dbz), 32'(ed));
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        s;

        reset    = 1'b0;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 32'(done), 32'd1);
            check("hold_q", quotient, 32'd14);
            check("hold_r", remainder, 32'd2);
        end

        run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run("u_ff_2", 1'b0, 32'hFFFF_FFFF, 32'd2,
            32'h7FFF_FFFF, 32'd1, 1'b0, 33);
        run("s_m1_2", 1'b1, 32'hFFFF_FFFF, 32'd2,
            32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run("dbz_u", 1'b0, 32'd1234, 32'd0,
            32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
        run("dbz_s", 1'b1, 32'd1234, 32'd0,
            32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
        run("dbz_neg", 1'b1, 32'hFFFF_FFF6, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b1, 1);
        run("s9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        run("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 1'b0, 33);
        run("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 32'h8000_0000, 1'b0, 33);

        // Second start during BUSY must be ignored.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        sign     = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("busy_start_lat", 32'(n + 10), 32'd33);
        check("busy_start_q", quotient, 32'd14);
        check("busy_start_r", remainder, 32'd2);

        // Asynchronous reset mid-division.
        launch(1'b0, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_dbz", 32'(dbz), 32'd0);
        check("mid_rst_q", quotient, 32'd0);
        check("mid_rst_r", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no_partial", 32'(done), 32'd0);
        run("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        for (int i = 0; i < 1000; i++) begin
            s = 1'(i & 1);
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = b >> $urandom_range(31, 0);
            if (i % 5 == 2) a = a >> $urandom_range(31, 0);
            if (i % 97 == 0) b = 32'd0;
            model(s, a, b, eq, er);
            launch(s, a, b);
            wait_done(n);
            check("rnd_lat", 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
            check("rnd_q", quotient, eq);
            check("rnd_r", remainder, er);
            if (b != 32'd0) begin
                check("rnd_inv", quotient * b + remainder, a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
